// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // One buffered fetch: the address of the following instruction plus the word itself.
    typedef struct packed {
        logic [31:0]        pc4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf_fifo.sv
// Two-entry {pc4, instr} FIFO between instruction memory and the IF/ID register.
// Flush wins over push/pop; push and pop may happen on the same edge.
module fetch_buf_fifo
    import mips_pkg::*;
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_pop;
    logic       do_push;

    assign do_pop  = pop && (count_reg != 2'd0);
    assign do_push = push && ((count_reg != 2'd2) || do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload registers need no reset: they are only observed while count is non-zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        fetch_entry_t entry_reg;
        always_ff @(posedge clock) begin
            if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
                entry_reg <= wdata;
            end
        end
    end

    assign head  = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign count = count_reg;

    // The credit scheme upstream must never deliver data into a full buffer.
    no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && (count_reg == 2'd2)));

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// read port and feeds a two-entry buffer whose head drives the IF/ID register.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock__i,
    input  logic        reset_n__i,
    input  logic        stall__i,
    input  logic        redirect__i,
    input  logic [31:0] redirect_pc__i,
    output logic        imem_req__o,
    output logic [31:0] imem_addr__o,
    input  logic        imem_gnt__i,
    input  logic        imem_rvalid__i,
    input  logic [31:0] imem_rdata__i,
    output logic [31:0] PC_4__o,
    output logic [31:0] instr__o,
    output logic        fetch_valid__o
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [2:0] CREDITS  = 3'(BUF_DEPTH);

    logic [1:0]   state_reg;
    logic [1:0]   state_next;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic [31:0]  tag_reg;
    logic [31:0]  tag_next;
    logic         outstanding_reg;
    logic         outstanding_next;

    logic         in_run;
    logic         pop;
    logic         push;
    logic         req;
    logic         grant;
    logic [2:0]   inflight;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t wdata;

    assign in_run = (state_reg == ST_RUN);
    assign pop    = !stall__i && (count != 2'd0) && !redirect__i;

    // Words already buffered plus the one in flight, net of this cycle's pop.
    assign inflight = {1'b0, count} + {2'b00, outstanding_reg} - {2'b00, pop};

    assign req   = in_run && !redirect__i && (!outstanding_reg || imem_rvalid__i)
                   && (inflight < CREDITS);
    assign grant = req && imem_gnt__i;

    // rvalid without a tracked request (stale after reset) never reaches the buffer.
    assign push  = in_run && !redirect__i && outstanding_reg && imem_rvalid__i;
    assign wdata = '{pc4: tag_reg, instr: imem_rdata__i};

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        tag_next         = tag_reg;
        outstanding_next = outstanding_reg;

        if (grant) begin
            outstanding_next = 1'b1;
            pc_next          = pc_reg + 32'd4;
            tag_next         = pc_reg + 32'd4;
        end else if (imem_rvalid__i) begin
            outstanding_next = 1'b0;
        end

        if (redirect__i) begin
            pc_next = {redirect_pc__i[31:2], 2'b00};
        end

        case (state_reg)
            ST_IDLE:  state_next = ST_RUN;
            ST_RUN: begin
                if (redirect__i && outstanding_reg && !imem_rvalid__i) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid__i) begin
                    state_next = ST_RUN;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            tag_reg         <= 32'h0;
            outstanding_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            tag_reg         <= tag_next;
            outstanding_reg <= outstanding_next;
        end
    end

    fetch_buf_fifo u_buf (
        .clock   (clock__i),
        .reset_n (reset_n__i),
        .push    (push),
        .pop     (pop),
        .flush   (redirect__i),
        .wdata   (wdata),
        .head    (head),
        .count   (count)
    );

    assign imem_req__o    = req;
    assign imem_addr__o   = pc_reg;
    assign fetch_valid__o = (count != 2'd0);
    assign PC_4__o        = fetch_valid__o ? head.pc4 : 32'h0;
    assign instr__o       = fetch_valid__o ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a zero-wait memory whose data is addr ^ 32'hA5A5_0000.
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;

    // Memory model: grants immediately, answers one cycle later unless held off.
    logic        hold = 1'b0;
    logic        pend_valid = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign gnt    = req;
    assign rvalid = pend_valid && !hold;
    assign rdata  = pend_addr ^ KEY;

    always @(posedge clk) begin
        if (rvalid) pend_valid <= 1'b0;
        if (req && gnt) begin
            pend_valid <= 1'b1;
            pend_addr  <= addr;
        end
    end

    if_fetch_stage dut (
        .clock__i       (clk),
        .reset_n__i     (rst_n),
        .stall__i       (stall),
        .redirect__i    (redirect),
        .redirect_pc__i (redirect_pc),
        .imem_req__o    (req),
        .imem_addr__o   (addr),
        .imem_gnt__i    (gnt),
        .imem_rvalid__i (rvalid),
        .imem_rdata__i  (rdata),
        .PC_4__o        (pc4),
        .instr__o       (instr),
        .fetch_valid__o (valid)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        hold;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] p,
                                input logic h, input logic q, input logic [31:0] a,
                                input logic v, input logic [31:0] c, input logic [31:0] n);
        vec_t t;
        t.rst_n = r; t.stall = s; t.redir = d; t.rpc = p; t.hold = h;
        t.req = q; t.addr = a; t.valid = v; t.pc4 = c; t.instr = n;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic d, input logic [31:0] p, input logic h);
        @(posedge clk);
        #1;
        stall = s; redirect = d; redirect_pc = p; hold = h;
        @(negedge clk);
        $display("cyc: stall=%0b redir=%0b req=%0b addr=%h valid=%0b pc4=%h instr=%h",
                 s, d, req, addr, valid, pc4, instr);
    endtask

    initial begin
        logic found;
        //                rst st rd rpc           hd  req addr          v  pc4           instr
        vecs.push_back(mk(0, 0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h4,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h8,         1, 32'h4,        32'hA5A5_0000));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0,  0, 32'hC,         1, 32'h8,        32'hA5A5_0004));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0,  0, 32'hC,         1, 32'h8,        32'hA5A5_0004));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0,  0, 32'hC,         1, 32'h8,        32'hA5A5_0004));
        vecs.push_back(mk(1, 1, 0, 32'h0,        0,  0, 32'hC,         1, 32'h8,        32'hA5A5_0004));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'hC,         1, 32'h8,        32'hA5A5_0004));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h10,        1, 32'hC,        32'hA5A5_0008));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h14,        1, 32'h10,       32'hA5A5_000C));
        vecs.push_back(mk(1, 0, 1, 32'h100,      1,  0, 32'h18,        1, 32'h14,       32'hA5A5_0010));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  0, 32'h100,       0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h100,       0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h104,       0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h108,       1, 32'h104,      32'hA5A5_0100));
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFE, 0, 0, 32'h10C,       1, 32'h108,      32'hA5A5_0104));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h4,         1, 32'h0,        32'h5A5A_FFFC));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h8,         1, 32'h4,        32'hA5A5_0000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1,  0, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  0, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h0,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h4,         0, 32'h0,        32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,        0,  1, 32'h8,         1, 32'h4,        32'hA5A5_0000));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n       = vecs[i].rst_n;
            stall       = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            hold        = vecs[i].hold;
            @(negedge clk);
            $display("vec %0d: rst_n=%0b req=%0b addr=%h valid=%0b pc4=%h instr=%h",
                     i, rst_n, req, addr, valid, pc4, instr);
            check($sformatf("v%0d.req", i),   32'(req),   32'(vecs[i].req));
            check($sformatf("v%0d.addr", i),  addr,       vecs[i].addr);
            check($sformatf("v%0d.valid", i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("v%0d.pc4", i),   pc4,        vecs[i].pc4);
            check($sformatf("v%0d.instr", i), instr,      vecs[i].instr);
        end

        // Redirect with the addr-8 read still pending, then redirect again while draining.
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check("drain.enter_req",   32'(req),   32'h0);
        check("drain.enter_pc4",   pc4,        32'h8);
        step(1'b0, 1'b1, 32'h303, 1'b1);
        check("drain.redir2_req",  32'(req),   32'h0);
        check("drain.redir2_addr", addr,       32'h200);
        check("drain.redir2_vld",  32'(valid), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("drain.ret_req",     32'(req),   32'h0);
        check("drain.ret_addr",    addr,       32'h300);
        check("drain.ret_vld",     32'(valid), 32'h0);

        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (valid) found = 1'b1;
        end
        check("drain.found",  32'(found), 32'h1);
        check("drain.pc4",    pc4,        32'h304);
        check("drain.instr",  instr,      32'hA5A5_0300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
